// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and elaboration helpers for the PLL reset sequencer.
// State codes are fixed so the debug output decodes the same way in every build.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLLRST   = 3'd0,
        WAITLOCK = 3'd1,
        STABLE   = 3'd2,
        RUN      = 3'd3,
        FAIL     = 3'd4
    } state_e;

    // Counter width sized for the longest of the three timed phases.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    function automatic bit params_ok(input int pllrst_cycles, input int lock_timeout,
                                     input int stable_cycles, input int max_retries,
                                     input int sync_stages);
        return (pllrst_cycles >= 1) && (lock_timeout >= 1) && (stable_cycles >= 1) &&
               (max_retries >= 1) && (max_retries <= 15) && (sync_stages >= 2);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; all stages reset to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, waits for a stable synchronized lock, then releases core reset.
// Lock loss or timeout retries the sequence; too many failed attempts park in FAIL.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLLRST_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_in,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [2:0] state_o
);

    localparam int CW = cnt_width(PLLRST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] PLLRST_LAST  = CW'(PLLRST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);
    localparam logic [3:0]    RETRY_LAST   = 4'(MAX_RETRIES - 1);

    if (!params_ok(PLLRST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, MAX_RETRIES, SYNC_STAGES)) begin : g_bad_params
        $error("pll_reset_sequencer: illegal parameter combination");
    end

    logic locked_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked_in),
        .q   (locked_s)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          pll_rst_q, sys_rst_q, ready_q, fail_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (soft_reset) begin
            state_d = PLLRST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                PLLRST: begin
                    if (cnt_q == PLLRST_LAST) begin
                        state_d = WAITLOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAITLOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        // Saturating count: FAIL is reached before it could ever wrap.
                        if (retry_q < RETRY_MAX) retry_d = retry_q + 1'b1;
                        cnt_d = '0;
                        if (retry_q >= RETRY_LAST) state_d = FAIL;
                        else                       state_d = PLLRST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAITLOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = PLLRST;
                        cnt_d   = '0;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = PLLRST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as state_q.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= PLLRST;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == PLLRST);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
            fail_q    <= (state_d == FAIL);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst     = sys_rst_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_in = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_rst, sys_rst, ready, fail;
    logic [3:0] retry_count;
    logic [2:0] state_o;

    int n_vec  = 0;
    int n_miss = 0;

    pll_reset_sequencer #(
        .PLLRST_CYCLES (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .SYNC_STAGES   (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked_in   (locked_in),
        .soft_reset  (soft_reset),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .state_o     (state_o)
    );

    always #10 refclk = ~refclk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int hi_cnt;
        int sys_low_cnt;

        // Scenario 1: power-up lock
        locked_in  = 1'b0;
        soft_reset = 1'b0;
        tick(2);
        check("rst_pll_rst", 8'(pll_rst), 8'd1);
        check("rst_sys_rst", 8'(sys_rst), 8'd1);
        check("rst_ready",   8'(ready),   8'd0);
        check("rst_fail",    8'(fail),    8'd0);
        check("rst_retry",   8'(retry_count), 8'd0);
        check("rst_state",   8'(state_o), 8'd0);
        rst = 1'b0;
        tick(3);
        check("s1_pllrst_hi", 8'(pll_rst), 8'd1);
        tick(1);
        check("s1_pllrst_lo", 8'(pll_rst), 8'd0);
        check("s1_waitlock",  8'(state_o), 8'd1);
        locked_in = 1'b1;
        tick(10);
        check("s1_ready_early", 8'(ready),   8'd0);
        check("s1_sysrst_early", 8'(sys_rst), 8'd1);
        check("s1_stable",      8'(state_o), 8'd2);
        tick(1);
        check("s1_ready",  8'(ready),   8'd1);
        check("s1_sysrst", 8'(sys_rst), 8'd0);
        check("s1_run",    8'(state_o), 8'd3);
        check("s1_retry",  8'(retry_count), 8'd0);

        // Scenario 4: lock loss in RUN
        locked_in = 1'b0;
        tick(2);
        check("s4_still_ready", 8'(ready), 8'd1);
        tick(1);
        check("s4_state",  8'(state_o), 8'd0);
        check("s4_sysrst", 8'(sys_rst), 8'd1);
        check("s4_ready",  8'(ready),   8'd0);
        check("s4_pllrst", 8'(pll_rst), 8'd1);
        tick(3);
        check("s4_pllrst_hold", 8'(pll_rst), 8'd1);
        tick(1);
        check("s4_pllrst_end", 8'(pll_rst), 8'd0);
        check("s4_waitlock",   8'(state_o), 8'd1);
        locked_in = 1'b1;
        tick(10);
        check("s4_relock_early", 8'(ready), 8'd0);
        tick(1);
        check("s4_relock", 8'(ready), 8'd1);

        // Scenario 3: one-cycle glitch during STABLE
        locked_in = 1'b0;
        do_reset();
        tick(4);
        check("s3_waitlock", 8'(state_o), 8'd1);
        locked_in = 1'b1;
        tick(6);
        locked_in = 1'b0;
        tick(1);
        locked_in = 1'b1;
        tick(1);
        check("s3_stable_cnt5", 8'(state_o), 8'd2);
        tick(1);
        check("s3_back_wait", 8'(state_o), 8'd1);
        check("s3_no_pllrst", 8'(pll_rst), 8'd0);
        tick(1);
        check("s3_restable", 8'(state_o), 8'd2);
        tick(7);
        check("s3_ready_early", 8'(ready), 8'd0);
        tick(1);
        check("s3_ready", 8'(ready),   8'd1);
        check("s3_run",   8'(state_o), 8'd3);

        // Scenario 2: lock never arrives
        locked_in = 1'b0;
        do_reset();
        hi_cnt = 0;
        sys_low_cnt = 0;
        for (int i = 1; i <= 72; i++) begin
            tick(1);
            if (pll_rst) hi_cnt++;
            if (!sys_rst) sys_low_cnt++;
            if (i == 24) begin
                check("s2_retry1", 8'(retry_count), 8'd1);
                check("s2_state1", 8'(state_o),     8'd0);
            end
            if (i == 48) begin
                check("s2_retry2", 8'(retry_count), 8'd2);
                check("s2_state2", 8'(state_o),     8'd0);
            end
        end
        check("s2_pllrst_cycles", 8'(hi_cnt),      8'd11);
        check("s2_sysrst_stuck",  8'(sys_low_cnt), 8'd0);
        check("s2_fail",  8'(fail),        8'd1);
        check("s2_state", 8'(state_o),     8'd4);
        check("s2_retry", 8'(retry_count), 8'd3);
        tick(30);
        check("s2_fail_hold",  8'(state_o),     8'd4);
        check("s2_retry_hold", 8'(retry_count), 8'd3);
        check("s2_pllrst_idle", 8'(pll_rst),    8'd0);

        // Scenario 5: soft_reset out of FAIL
        locked_in  = 1'b1;
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        check("s5_state", 8'(state_o),     8'd0);
        check("s5_fail",  8'(fail),        8'd0);
        check("s5_retry", 8'(retry_count), 8'd0);
        tick(12);
        check("s5_stable",      8'(state_o), 8'd2);
        check("s5_ready_early", 8'(ready),   8'd0);
        tick(1);
        check("s5_ready", 8'(ready), 8'd1);

        // Scenario 6: asynchronous reset mid-STABLE
        locked_in = 1'b1;
        do_reset();
        tick(5);
        check("s6_stable_entry", 8'(state_o), 8'd2);
        tick(3);
        check("s6_stable", 8'(state_o), 8'd2);
        #3;
        rst = 1'b1;
        #1;
        check("s6_pllrst", 8'(pll_rst), 8'd1);
        check("s6_sysrst", 8'(sys_rst), 8'd1);
        check("s6_ready",  8'(ready),   8'd0);
        check("s6_state",  8'(state_o), 8'd0);
        tick(1);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
